// File: rtl/bcd2bin_conv.sv
// bcd2bin_conv: sequential packed-BCD to binary converter (reverse double-dabble).
// Each iteration shifts the combined {bcd, binary} register right by one bit.
// Between shifts, every BCD digit that is 8 or greater has 3 subtracted from it.
// Digit validation happens once, before the first shift.
module bcd2bin_conv #(
  parameter int unsigned NDIG = 4,
  parameter int unsigned BW   = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic [BW-1:0]     bin_out,
  output logic              done,
  output logic              busy,
  output logic              error,
  output logic [2:0]        current_state
);

  localparam int unsigned DW = 4 * NDIG;
  localparam int unsigned SW = DW + BW;
  localparam int unsigned CW = $clog2(BW + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SHIFT  = 3'd2,
    ADJUST = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [SW-1:0] sr;
  logic [CW-1:0] cnt;

  logic          digit_bad;
  logic [SW-1:0] sr_shift;
  logic [SW-1:0] sr_adj;
  logic [CW-1:0] cnt_dec;

  // Per-digit datapath helpers: the validity check, the -3 adjust, the shift and the count-down
  always_comb begin
    logic [3:0] d;
    digit_bad = 1'b0;
    sr_adj    = sr;
    for (int unsigned i = 0; i < NDIG; i++) begin
      d = sr[BW + 4*i +: 4];
      if (d > 4'd9) digit_bad = 1'b1;
      if (d >= 4'd8) sr_adj[BW + 4*i +: 4] = d - 4'd3;
    end
    sr_shift = sr >> 1;
    cnt_dec  = cnt - 1'b1;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_nxt     = IDLE;
    done          = 1'b0;
    busy          = 1'b0;
    current_state = state;
    case (state)
      IDLE:   state_nxt = start ? CHECK : IDLE;
      CHECK: begin
        busy      = 1'b1;
        state_nxt = digit_bad ? DONE : SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        state_nxt = (cnt_dec == '0) ? DONE : ADJUST;
      end
      ADJUST: begin
        busy      = 1'b1;
        state_nxt = SHIFT;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? DONE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, shift/adjust iterations, result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr      <= '0;
      cnt     <= '0;
      bin_out <= '0;
      error   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sr  <= {bcd_in, {BW{1'b0}}};
            cnt <= CW'(BW);
          end
        end
        CHECK: begin
          if (digit_bad) begin
            bin_out <= '0;
            error   <= 1'b1;
          end
        end
        SHIFT: begin
          sr  <= sr_shift;
          cnt <= cnt_dec;
          // error is cleared together with the result load so that both only
          // change on entry to DONE and hold steady through a conversion
          if (cnt_dec == '0) begin
            bin_out <= sr_shift[BW-1:0];
            error   <= 1'b0;
          end
        end
        ADJUST: sr <= sr_adj;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_conv.sv
// tb_bcd2bin_conv: directed bench for bcd2bin_conv with an expected-result queue.
module tb_bcd2bin_conv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bcd_in;
  logic [13:0] bin_out;
  logic        done;
  logic        busy;
  logic        error;
  logic [2:0]  current_state;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [13:0] bin;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  bcd2bin_conv #(.NDIG(4), .BW(14)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bcd_in       (bcd_in),
    .bin_out      (bin_out),
    .done         (done),
    .busy         (busy),
    .error        (error),
    .current_state(current_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one conversion; push its expectation, wait for DONE, pop and compare.
  task automatic convert(input logic [15:0] b, input int expv, input bit experr,
                         input int lat, input bit hold, input bit scramble);
    exp_t e;
    exp_t got;
    int   n;
    e.bin = expv[13:0];
    e.err = experr;
    e.lat = lat;
    @(negedge clk);
    bcd_in = b;
    start  = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;   // E0
    chk("accept_busy", busy, 1);
    chk("accept_state", current_state, 1);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      if (scramble) begin
        @(negedge clk);
        bcd_in = 16'($urandom);
        start  = 1'($urandom);
      end
      @(posedge clk); #1;
      if (done) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk("done_timeout", 0, 1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      got = sb.pop_front();
      chk("latency", n, got.lat);
      chk("bin_out", bin_out, got.bin);
      chk("error", error, got.err);
      chk("busy_in_done", busy, 0);
    end
    if (hold) begin
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        chk("hold_state", current_state, 4);
        chk("hold_bin", bin_out, expv);
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("back_to_idle", current_state, 0);
    chk("done_low_idle", done, 0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_bin", bin_out, 0);
    chk("rst_err", error, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", current_state, 0);

    convert(16'h0000, 0,    0, 28, 0, 0);
    convert(16'h9999, 9999, 0, 28, 0, 0);
    convert(16'h1234, 1234, 0, 28, 0, 0);
    convert(16'h0805, 805,  0, 28, 0, 0);
    convert(16'h12A4, 0,    1, 1,  0, 0);
    convert(16'h0042, 42,   0, 28, 0, 0);
    convert(16'h0777, 777,  0, 28, 1, 0);
    convert(16'h0321, 321,  0, 28, 0, 0);
    convert(16'h4321, 4321, 0, 28, 0, 1);

    // Abort a conversion of 5678 with reset ten edges after accept
    @(negedge clk);
    bcd_in = 16'h5678;
    start  = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("pre_abort_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_bin", bin_out, 0);
    chk("abort_err", error, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_state", current_state, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_abort_idle", current_state, 0);
    convert(16'h0001, 1, 0, 28, 0, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
